imem_loader: RTL

Program loader directly upstream of the single-cycle core's instruction memory and fetch stage. Accepts 32-bit instruction words over a valid/ready stream and writes them to consecutive instruction-memory addresses starting at word 0. Holds the core's fetch enable low while loading and asserts it once the final word has been committed. Reports word count, a running XOR checksum, and overflow.

---
 rtl/imem_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Purpose: streams program words into instruction memory from word 0, then releases the core's fetch enable.
// Latency: one write per accept, registered one cycle after the accept edge; core_en rises two edges after the last accept.
// Backpressure: in_ready is high only in LOAD and depends on state alone; any in_valid outside LOAD is left pending.
module imem_loader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              core_en,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_FLUSH = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   // Highest word address; an accept here without in_last means the program does not fit.
   localparam logic [ADDR_W-1:0] PTR_MAX = '1;

   logic [2:0]        state_q;
   logic [2:0]        state_d;
   logic [ADDR_W-1:0] ptr_q;
   logic              pend_err_q;
   logic              accept;
   logic              reload;
   logic              overflow;

   // Ready is a pure state decode so the source never sees a combinational loop through in_valid.
   assign in_ready = (state_q == S_LOAD);
   assign accept   = in_valid & in_ready;

   // start only restarts a load from the quiescent states; LOAD and FLUSH ignore it.
   assign reload   = start & ((state_q == S_IDLE) | (state_q == S_RUN) | (state_q == S_ERR));

   // Last slot filled and the source still has more to send.
   assign overflow = accept & ~in_last & (ptr_q == PTR_MAX);

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (reload) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (accept && (in_last || overflow)) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            // One cycle gap so the final write commits before the core may fetch.
            state_d = pend_err_q ? S_ERR : S_RUN;
         end
         S_RUN: begin
            if (reload) state_d = S_LOAD;
         end
         S_ERR: begin
            if (reload) state_d = S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Memory write port: strobe follows the accept by one edge; address/data hold between writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= accept;
         if (accept) begin
            mem_addr  <= ptr_q;
            mem_wdata <= in_data;
         end
      end
   end

   // Write pointer and the error flag carried from the final accept into FLUSH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q      <= '0;
         pend_err_q <= 1'b0;
      end else begin
         if (reload) begin
            ptr_q      <= '0;
            pend_err_q <= 1'b0;
         end else if (accept) begin
            // Wraps to 0 after the last slot, but LOAD is always left at that point.
            ptr_q      <= ptr_q + 1'b1;
            pend_err_q <= overflow;
         end
      end
   end

   // Load statistics, cleared at the start of each load and frozen outside LOAD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_count <= '0;
         checksum   <= '0;
      end else begin
         if (reload) begin
            word_count <= '0;
            checksum   <= '0;
         end else if (accept) begin
            word_count <= word_count + 1'b1;
            checksum   <= checksum ^ in_data;
         end
      end
   end

   // Status flags: core_en/done set on leaving FLUSH cleanly, err on leaving it with overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_en <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         if (reload) begin
            // The core stops on the same edge the reload begins.
            core_en <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
         end else if (state_q == S_FLUSH) begin
            if (pend_err_q) begin
               err <= 1'b1;
            end else begin
               core_en <= 1'b1;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule
